// File: rtl/load_store_unit_pkg.sv
// Shared types and helpers for the MEM-stage load/store unit.
// Holds the FSM state encoding, the funct3 encodings and the access-size decode.
package load_store_unit_pkg;

  typedef enum logic [1:0] {
    LSU_IDLE = 2'd0,
    LSU_REQ  = 2'd1,
    LSU_WAIT = 2'd2
  } lsu_state_e;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } access_size_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  // Any encoding that is not a legal load/store of that direction is a word access.
  function automatic access_size_e access_size(input logic [2:0] f3, input logic is_store);
    access_size_e sz;
    case (f3)
      F3_LB:   sz = SZ_BYTE;
      F3_LH:   sz = SZ_HALF;
      F3_LBU:  sz = is_store ? SZ_WORD : SZ_BYTE;
      F3_LHU:  sz = is_store ? SZ_WORD : SZ_HALF;
      default: sz = SZ_WORD;
    endcase
    return sz;
  endfunction

endpackage

// File: rtl/load_store_unit_lsu_align.sv
// Combinational byte-lane datapath: store strobes/replication, misalignment detection,
// and load lane extraction with sign/zero extension.
module lsu_align
  import load_store_unit_pkg::*;
(
  input  logic [1:0]  req_addr_lo,
  input  logic [2:0]  req_funct3,
  input  logic        req_we,
  input  logic [31:0] req_store_data,
  output logic [3:0]  wstrb,
  output logic [31:0] wdata,
  output logic        misalign,
  input  logic [1:0]  ld_addr_lo,
  input  logic [2:0]  ld_funct3,
  input  logic [31:0] ld_rdata,
  output logic [31:0] ld_data
);

  access_size_e req_size;
  access_size_e ld_size;
  logic [7:0]   ld_byte;
  logic [15:0]  ld_half;

  // Request side: strobes, lane-replicated write data and alignment check.
  always_comb begin
    req_size = access_size(req_funct3, req_we);
    wstrb    = 4'b1111;
    wdata    = req_store_data;
    misalign = 1'b0;
    case (req_size)
      SZ_BYTE: begin
        wstrb    = 4'b0001 << req_addr_lo;
        wdata    = {4{req_store_data[7:0]}};
        misalign = 1'b0;
      end
      SZ_HALF: begin
        wstrb    = 4'b0011 << {req_addr_lo[1], 1'b0};
        wdata    = {2{req_store_data[15:0]}};
        misalign = req_addr_lo[0];
      end
      default: begin
        wstrb    = 4'b1111;
        wdata    = req_store_data;
        misalign = |req_addr_lo;
      end
    endcase
  end

  // Response side: pick the addressed lane; funct3[2] selects zero extension.
  always_comb begin
    ld_size = access_size(ld_funct3, 1'b0);
    case (ld_addr_lo)
      2'd0:    ld_byte = ld_rdata[7:0];
      2'd1:    ld_byte = ld_rdata[15:8];
      2'd2:    ld_byte = ld_rdata[23:16];
      default: ld_byte = ld_rdata[31:24];
    endcase
    if (ld_addr_lo[1]) begin
      ld_half = ld_rdata[31:16];
    end else begin
      ld_half = ld_rdata[15:0];
    end
    case (ld_size)
      SZ_BYTE: ld_data = {{24{ld_byte[7] & ~ld_funct3[2]}}, ld_byte};
      SZ_HALF: ld_data = {{16{ld_half[15] & ~ld_funct3[2]}}, ld_half};
      default: ld_data = ld_rdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// MEM-stage load/store unit: ALU passthrough plus a req/gnt/rvalid data-bus engine.
// Holds the access FSM, the captured operation and the writeback-side output registers.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            valid_i,
  input  logic [4:0]      rd_addr_i,
  input  logic [XLEN-1:0] rd_data_i,
  input  logic            rd_we_i,
  input  logic            mem_req_i,
  input  logic            mem_we_i,
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] store_data_i,
  output logic            stall_o,
  output logic            dbus_req_o,
  output logic [XLEN-1:0] dbus_addr_o,
  output logic            dbus_we_o,
  output logic [3:0]      dbus_wstrb_o,
  output logic [XLEN-1:0] dbus_wdata_o,
  input  logic            dbus_gnt_i,
  input  logic            dbus_rvalid_i,
  input  logic [XLEN-1:0] dbus_rdata_i,
  output logic [4:0]      rd_addr_o,
  output logic [XLEN-1:0] rd_data_o,
  output logic            rd_we_o,
  output logic            misalign_o
);

  lsu_state_e      state_q, state_d;
  logic [XLEN-1:2] op_addr_q, op_addr_d;
  logic [1:0]      op_addr_lo_q, op_addr_lo_d;
  logic [2:0]      op_funct3_q, op_funct3_d;
  logic            op_we_q, op_we_d;
  logic [3:0]      op_wstrb_q, op_wstrb_d;
  logic [XLEN-1:0] op_wdata_q, op_wdata_d;
  logic [4:0]      op_rd_addr_q, op_rd_addr_d;
  logic            op_rd_we_q, op_rd_we_d;
  logic [4:0]      rd_addr_q, rd_addr_d;
  logic [XLEN-1:0] rd_data_q, rd_data_d;
  logic            rd_we_q, rd_we_d;
  logic            misalign_q, misalign_d;

  logic [3:0]      align_wstrb;
  logic [XLEN-1:0] align_wdata;
  logic            align_misalign;
  logic [XLEN-1:0] align_ld_data;

  lsu_align u_align (
    .req_addr_lo    (rd_data_i[1:0]),
    .req_funct3     (funct3_i),
    .req_we         (mem_we_i),
    .req_store_data (store_data_i),
    .wstrb          (align_wstrb),
    .wdata          (align_wdata),
    .misalign       (align_misalign),
    .ld_addr_lo     (op_addr_lo_q),
    .ld_funct3      (op_funct3_q),
    .ld_rdata       (dbus_rdata_i),
    .ld_data        (align_ld_data)
  );

  // Next-state, capture and writeback decisions; stall releases on the rvalid cycle.
  always_comb begin
    state_d      = state_q;
    op_addr_d    = op_addr_q;
    op_addr_lo_d = op_addr_lo_q;
    op_funct3_d  = op_funct3_q;
    op_we_d      = op_we_q;
    op_wstrb_d   = op_wstrb_q;
    op_wdata_d   = op_wdata_q;
    op_rd_addr_d = op_rd_addr_q;
    op_rd_we_d   = op_rd_we_q;
    rd_addr_d    = rd_addr_q;
    rd_data_d    = rd_data_q;
    rd_we_d      = 1'b0;
    misalign_d   = 1'b0;
    stall_o      = 1'b0;
    case (state_q)
      LSU_IDLE: begin
        if (valid_i && mem_req_i) begin
          if (align_misalign) begin
            misalign_d = 1'b1;
          end else begin
            op_addr_d    = rd_data_i[XLEN-1:2];
            op_addr_lo_d = rd_data_i[1:0];
            op_funct3_d  = funct3_i;
            op_we_d      = mem_we_i;
            op_wstrb_d   = align_wstrb;
            op_wdata_d   = align_wdata;
            op_rd_addr_d = rd_addr_i;
            op_rd_we_d   = rd_we_i;
            stall_o      = 1'b1;
            state_d      = LSU_REQ;
          end
        end else if (valid_i) begin
          rd_addr_d = rd_addr_i;
          rd_data_d = rd_data_i;
          rd_we_d   = rd_we_i;
        end else begin
          rd_we_d = 1'b0;
        end
      end
      LSU_REQ: begin
        stall_o = 1'b1;
        if (dbus_gnt_i) begin
          state_d = LSU_WAIT;
        end else begin
          state_d = LSU_REQ;
        end
      end
      LSU_WAIT: begin
        if (dbus_rvalid_i) begin
          state_d   = LSU_IDLE;
          rd_addr_d = op_rd_addr_q;
          if (!op_we_q) begin
            rd_data_d = align_ld_data;
            rd_we_d   = op_rd_we_q;
          end else begin
            rd_we_d = 1'b0;
          end
        end else begin
          stall_o = 1'b1;
        end
      end
      default: state_d = LSU_IDLE;
    endcase
  end

  // State, captured-op and output registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q      <= LSU_IDLE;
      op_addr_q    <= '0;
      op_addr_lo_q <= 2'b00;
      op_funct3_q  <= 3'b000;
      op_we_q      <= 1'b0;
      op_wstrb_q   <= 4'b0000;
      op_wdata_q   <= '0;
      op_rd_addr_q <= 5'd0;
      op_rd_we_q   <= 1'b0;
      rd_addr_q    <= 5'd0;
      rd_data_q    <= '0;
      rd_we_q      <= 1'b0;
      misalign_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      op_addr_q    <= op_addr_d;
      op_addr_lo_q <= op_addr_lo_d;
      op_funct3_q  <= op_funct3_d;
      op_we_q      <= op_we_d;
      op_wstrb_q   <= op_wstrb_d;
      op_wdata_q   <= op_wdata_d;
      op_rd_addr_q <= op_rd_addr_d;
      op_rd_we_q   <= op_rd_we_d;
      rd_addr_q    <= rd_addr_d;
      rd_data_q    <= rd_data_d;
      rd_we_q      <= rd_we_d;
      misalign_q   <= misalign_d;
    end
  end

  assign dbus_req_o   = (state_q == LSU_REQ);
  assign dbus_addr_o  = {op_addr_q, 2'b00};
  assign dbus_we_o    = op_we_q;
  assign dbus_wstrb_o = op_wstrb_q;
  assign dbus_wdata_o = op_wdata_q;
  assign rd_addr_o    = rd_addr_q;
  assign rd_data_o    = rd_data_q;
  assign rd_we_o      = rd_we_q;
  assign misalign_o   = misalign_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized scoreboard bench for load_store_unit: a driver, a bus responder and a
// writeback monitor run concurrently against a plain-arithmetic reference model.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_i, valid_i, rd_we_i, mem_req_i, mem_we_i;
  logic [4:0]  rd_addr_i;
  logic [31:0] rd_data_i, store_data_i;
  logic [2:0]  funct3_i;
  logic        stall_o, dbus_req_o, dbus_we_o, dbus_gnt_i, dbus_rvalid_i;
  logic [31:0] dbus_addr_o, dbus_wdata_o, dbus_rdata_i;
  logic [3:0]  dbus_wstrb_o;
  logic [4:0]  rd_addr_o;
  logic [31:0] rd_data_o;
  logic        rd_we_o, misalign_o;

  load_store_unit #(.XLEN(32)) dut (
    .clk_i(clk), .rst_i(rst_i), .valid_i(valid_i), .rd_addr_i(rd_addr_i),
    .rd_data_i(rd_data_i), .rd_we_i(rd_we_i), .mem_req_i(mem_req_i), .mem_we_i(mem_we_i),
    .funct3_i(funct3_i), .store_data_i(store_data_i), .stall_o(stall_o),
    .dbus_req_o(dbus_req_o), .dbus_addr_o(dbus_addr_o), .dbus_we_o(dbus_we_o),
    .dbus_wstrb_o(dbus_wstrb_o), .dbus_wdata_o(dbus_wdata_o), .dbus_gnt_i(dbus_gnt_i),
    .dbus_rvalid_i(dbus_rvalid_i), .dbus_rdata_i(dbus_rdata_i), .rd_addr_o(rd_addr_o),
    .rd_data_o(rd_data_o), .rd_we_o(rd_we_o), .misalign_o(misalign_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_mis;
    logic [4:0]  addr;
    logic [31:0] data;
  } wb_t;

  typedef struct {
    logic [31:0] addr;
    bit          we;
    logic [3:0]  strb;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          gnt_dly;
    int          rv_dly;
  } bus_t;

  wb_t  wb_q[$];
  bus_t bus_q[$];
  int   n_checks = 0;
  int   n_fail = 0;
  bit   resp_en = 1'b1;
  logic man_gnt = 1'b0, man_rvalid = 1'b0;
  logic [31:0] man_rdata = 32'h0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // 0 = byte, 1 = half, 2 = word; unknown encodings are word accesses
  function automatic int acc_size(input logic [2:0] f3, input bit st);
    case (f3)
      3'd0:    return 0;
      3'd1:    return 1;
      3'd4:    return st ? 2 : 0;
      3'd5:    return st ? 2 : 1;
      default: return 2;
    endcase
  endfunction

  // Present one op, push its expected effects, and hold it until the DUT stops stalling.
  task automatic issue(input bit mem, input bit we, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] sd, input logic [4:0] rd, input bit rdwe,
                       input int gdly, input int rdly, input logic [31:0] rdata);
    wb_t  w;
    bus_t b;
    int   sz, exp_stall, cnt;
    logic [7:0]  b8;
    logic [15:0] h16;
    exp_stall = 0;
    if (!mem) begin
      if (rdwe) begin w.is_mis = 1'b0; w.addr = rd; w.data = a; wb_q.push_back(w); end
    end else begin
      sz = acc_size(f3, we);
      if ((sz == 1 && a[0]) || (sz == 2 && a[1:0] != 2'b00)) begin
        w.is_mis = 1'b1; w.addr = 5'd0; w.data = 32'h0; wb_q.push_back(w);
      end else begin
        b.addr = a & 32'hFFFF_FFFC; b.we = we; b.rdata = rdata;
        b.gnt_dly = gdly; b.rv_dly = rdly;
        case (sz)
          0: begin b.strb = 4'(1 << a[1:0]); b.wdata = {4{sd[7:0]}}; end
          1: begin b.strb = 4'(3 << (2 * a[1])); b.wdata = {2{sd[15:0]}}; end
          default: begin b.strb = 4'hF; b.wdata = sd; end
        endcase
        bus_q.push_back(b);
        if (!we && rdwe) begin
          b8  = 8'(rdata >> (8 * a[1:0]));
          h16 = 16'(rdata >> (16 * a[1]));
          w.is_mis = 1'b0; w.addr = rd;
          if (sz == 0)      w.data = f3[2] ? {24'h0, b8} : {{24{b8[7]}}, b8};
          else if (sz == 1) w.data = f3[2] ? {16'h0, h16} : {{16{h16[15]}}, h16};
          else              w.data = rdata;
          wb_q.push_back(w);
        end
        exp_stall = 2 + gdly + rdly;
      end
    end
    valid_i = 1'b1; mem_req_i = mem; mem_we_i = we; funct3_i = f3; rd_data_i = a;
    store_data_i = sd; rd_addr_i = rd; rd_we_i = rdwe;
    cnt = 0;
    forever begin
      @(negedge clk);
      if (!stall_o) break;
      cnt++;
      if (cnt > 60) begin
        n_checks++; n_fail++;
        $display("FAIL stall_timeout: stall_o still 1 after %0d cycles, required release", cnt);
        break;
      end
    end
    check("stall_cycles", 32'(cnt), 32'(exp_stall));
    @(posedge clk); #1;
    valid_i = 1'b0;
  endtask

  // Bus responder: checks each request against the model and answers with chosen delays.
  initial begin : responder
    bus_t cur;
    bit   seen, pending;
    int   gcnt, rcnt;
    seen = 1'b0; pending = 1'b0; gcnt = 0; rcnt = 0;
    cur = '{addr: 32'h0, we: 1'b0, strb: 4'h0, wdata: 32'h0, rdata: 32'h0, gnt_dly: 0, rv_dly: 0};
    dbus_gnt_i = 1'b0; dbus_rvalid_i = 1'b0; dbus_rdata_i = 32'h0;
    forever begin
      @(posedge clk); #1;
      if (!resp_en) begin
        dbus_gnt_i = man_gnt; dbus_rvalid_i = man_rvalid; dbus_rdata_i = man_rdata;
        seen = 1'b0; pending = 1'b0;
      end else begin
        dbus_gnt_i = 1'b0; dbus_rvalid_i = 1'b0; dbus_rdata_i = $urandom;
        if (pending) begin
          if (rcnt == 0) begin
            dbus_rvalid_i = 1'b1; dbus_rdata_i = cur.rdata; pending = 1'b0;
          end else begin
            rcnt--;
          end
          if ($urandom_range(0, 3) == 0) dbus_gnt_i = 1'b1;
        end else begin
          if ($urandom_range(0, 3) == 0) dbus_rvalid_i = 1'b1;
          if (dbus_req_o) begin
            if (!seen) begin
              if (bus_q.size() == 0) begin
                n_checks++; n_fail++;
                $display("FAIL bus_unexpected_req: dbus_req_o=1 addr %h, required no request", dbus_addr_o);
                cur.gnt_dly = 0; cur.rv_dly = 0; cur.addr = dbus_addr_o; cur.we = dbus_we_o;
                cur.strb = dbus_wstrb_o; cur.wdata = dbus_wdata_o;
              end else begin
                cur = bus_q.pop_front();
              end
              seen = 1'b1; gcnt = cur.gnt_dly;
            end
            check("bus_addr", dbus_addr_o, cur.addr);
            check("bus_we", 32'(dbus_we_o), 32'(cur.we));
            if (cur.we) begin
              check("bus_wstrb", 32'(dbus_wstrb_o), 32'(cur.strb));
              check("bus_wdata", dbus_wdata_o, cur.wdata);
            end
            if (gcnt == 0) begin
              dbus_gnt_i = 1'b1; seen = 1'b0; pending = 1'b1; rcnt = cur.rv_dly;
            end else begin
              gcnt--;
            end
          end else if ($urandom_range(0, 3) == 0) begin
            dbus_gnt_i = 1'b1;
          end
        end
      end
    end
  end

  // Writeback monitor: every rd_we_o or misalign_o pulse must match the next expectation.
  initial begin : monitor
    wb_t e;
    forever begin
      @(negedge clk);
      if (rst_i && (rd_we_o || misalign_o)) begin
        if (wb_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL wb_unexpected: rd_we_o=%0b misalign_o=%0b rd_addr_o=%0d rd_data_o=%h, required no event",
                   rd_we_o, misalign_o, rd_addr_o, rd_data_o);
        end else begin
          e = wb_q.pop_front();
          if (e.is_mis) begin
            check("mis_pulse", 32'(misalign_o), 32'd1);
            check("mis_rd_we", 32'(rd_we_o), 32'd0);
          end else begin
            check("wb_we", 32'(rd_we_o), 32'd1);
            check("wb_mis", 32'(misalign_o), 32'd0);
            check("wb_addr", 32'(rd_addr_o), 32'(e.addr));
            check("wb_data", rd_data_o, e.data);
          end
        end
      end
    end
  end

  task automatic check_idle_outputs(input string tag);
    check({tag, "_stall"}, 32'(stall_o), 32'd0);
    check({tag, "_req"}, 32'(dbus_req_o), 32'd0);
    check({tag, "_addr"}, dbus_addr_o, 32'h0);
    check({tag, "_wstrb"}, 32'(dbus_wstrb_o), 32'h0);
    check({tag, "_wdata"}, dbus_wdata_o, 32'h0);
    check({tag, "_rd_we"}, 32'(rd_we_o), 32'd0);
    check({tag, "_rd_addr"}, 32'(rd_addr_o), 32'd0);
    check({tag, "_rd_data"}, rd_data_o, 32'h0);
    check({tag, "_mis"}, 32'(misalign_o), 32'd0);
  endtask

  initial begin : main
    logic [2:0] f3;
    rst_i = 1'b0; valid_i = 1'b0; mem_req_i = 1'b0; mem_we_i = 1'b0; funct3_i = 3'd0;
    rd_data_i = 32'h0; store_data_i = 32'h0; rd_addr_i = 5'd0; rd_we_i = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle_outputs("reset");
    @(posedge clk); #1;
    rst_i = 1'b1;

    issue(1'b0, 1'b0, 3'd0, 32'h0000_1234, 32'h0, 5'd5, 1'b1, 0, 0, 32'h0);
    issue(1'b1, 1'b0, 3'd0, 32'h0000_0103, 32'h0, 5'd7, 1'b1, 0, 0, 32'h80FF_FF00);
    issue(1'b1, 1'b1, 3'd1, 32'h0000_0022, 32'hABCD_5678, 5'd3, 1'b1, 1, 1, 32'h0);
    issue(1'b1, 1'b0, 3'd2, 32'h0000_0041, 32'h0, 5'd9, 1'b1, 0, 0, 32'h0);
    issue(1'b1, 1'b0, 3'd5, 32'h0000_0002, 32'h0, 5'd4, 1'b1, 3, 1, 32'hBEEF_0000);
    issue(1'b1, 1'b0, 3'd2, 32'h0000_0040, 32'h0, 5'd0, 1'b1, 0, 2, 32'h1357_9BDF);

    for (int i = 0; i < 200; i++) begin
      f3 = 3'($urandom_range(0, 7));
      issue($urandom_range(0, 2) != 0, 1'($urandom), f3, $urandom, $urandom,
            5'($urandom), $urandom_range(0, 3) != 0,
            $urandom_range(0, 3), $urandom_range(0, 2), $urandom);
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end

    // Abandon an access with reset while waiting, then send a late rvalid.
    repeat (3) @(posedge clk);
    @(negedge clk);
    resp_en = 1'b0; man_gnt = 1'b0; man_rvalid = 1'b0;
    @(posedge clk); #1;
    valid_i = 1'b1; mem_req_i = 1'b1; mem_we_i = 1'b0; funct3_i = 3'd2;
    rd_data_i = 32'h0000_0040; rd_addr_i = 5'd9; rd_we_i = 1'b1;
    @(negedge clk);
    check("rst_accept_stall", 32'(stall_o), 32'd1);
    @(posedge clk); #1;
    valid_i = 1'b0;
    @(negedge clk);
    check("rst_req", 32'(dbus_req_o), 32'd1);
    check("rst_req_addr", dbus_addr_o, 32'h0000_0040);
    man_gnt = 1'b1;
    @(negedge clk);
    man_gnt = 1'b0;
    @(negedge clk);
    check("rst_wait_req", 32'(dbus_req_o), 32'd0);
    check("rst_wait_stall", 32'(stall_o), 32'd1);
    rst_i = 1'b0;
    @(negedge clk);
    rst_i = 1'b1;
    check_idle_outputs("midwait_reset");
    man_rvalid = 1'b1; man_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    check("late_rvalid_stall", 32'(stall_o), 32'd0);
    man_rvalid = 1'b0;
    @(negedge clk);
    check_idle_outputs("late_rvalid");

    check("wb_queue_drained", 32'(wb_q.size()), 32'd0);
    check("bus_queue_drained", 32'(bus_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
